// File: rtl/mac_rr_arbiter.sv
// -----------------------------------------------------------------------------
// mac_rr_arbiter
// Shares one external combinational multiply-add unit (d = a*b + c) among
// NUM_REQ requesters. A round-robin pointer picks the next requester. The
// winner's operands are registered toward the shared unit. The unit's result
// is captured one cycle later and returned with the requester index. Only one
// transaction is in flight at a time.
//
// Ports
//   clk_i        clock, rising edge
//   rst_i        synchronous reset, active-high
//   req_valid_i  per-requester request valid
//   req_ready_o  per-requester accept, one-hot or zero, combinational in IDLE
//   req_a_i/b_i/c_i  packed operands, requester k at [k*DATA_W +: DATA_W]
//   mac_a_o/b_o/c_o  registered operands to the shared unit
//   mac_d_i      result from the shared unit
//   rsp_valid_o  response valid
//   rsp_ready_i  response consumer ready
//   rsp_id_o     index of the requester owning the response
//   rsp_d_o      registered result
//   busy_o       high whenever a transaction is in flight
// -----------------------------------------------------------------------------
module mac_rr_arbiter #(
    parameter int  NUM_REQ = 4,
    parameter int  DATA_W  = 8,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [NUM_REQ-1:0]          req_valid_i,
    output logic [NUM_REQ-1:0]          req_ready_o,
    input  logic [NUM_REQ*DATA_W-1:0]   req_a_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_b_i,
    input  logic [NUM_REQ*DATA_W-1:0]   req_c_i,
    output logic [DATA_W-1:0]           mac_a_o,
    output logic [DATA_W-1:0]           mac_b_o,
    output logic [DATA_W-1:0]           mac_c_o,
    input  logic [2*DATA_W-1:0]         mac_d_i,
    output logic                        rsp_valid_o,
    input  logic                        rsp_ready_i,
    output logic [ID_W-1:0]             rsp_id_o,
    output logic [2*DATA_W-1:0]         rsp_d_o,
    output logic                        busy_o
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]          state_r;
    logic [ID_W-1:0]     rr_ptr_r;
    logic [ID_W-1:0]     rsp_id_r;
    logic [DATA_W-1:0]   mac_a_r;
    logic [DATA_W-1:0]   mac_b_r;
    logic [DATA_W-1:0]   mac_c_r;
    logic [2*DATA_W-1:0] rsp_d_r;
    logic                rsp_valid_r;

    logic                grant_found_s;
    logic [ID_W-1:0]     winner_s;
    logic [ID_W-1:0]     cand_s;
    logic [ID_W-1:0]     next_ptr_s;
    logic [NUM_REQ-1:0]  grant_oh_s;
    logic [NUM_REQ-1:0]  req_ready_s;
    logic [DATA_W-1:0]   win_a_s;
    logic [DATA_W-1:0]   win_b_s;
    logic [DATA_W-1:0]   win_c_s;

    // Modular add of two indices below NUM_REQ; one subtraction suffices
    // because the sum is always below 2*NUM_REQ, even for non-power-of-two NUM_REQ.
    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                 input logic [ID_W-1:0] off);
        logic [ID_W:0] sum;
        sum = {1'b0, base} + {1'b0, off};
        if (sum >= (ID_W+1)'(NUM_REQ)) begin
            sum = sum - (ID_W+1)'(NUM_REQ);
        end else begin
            sum = sum;
        end
        return sum[ID_W-1:0];
    endfunction

    // Round-robin search: first valid requester starting at rr_ptr_r.
    always_comb begin
        grant_found_s = 1'b0;
        winner_s      = '0;
        cand_s        = '0;
        grant_oh_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_s = wrap_add(rr_ptr_r, ID_W'(i));
            if (!grant_found_s && req_valid_i[cand_s]) begin
                grant_found_s      = 1'b1;
                winner_s           = cand_s;
                grant_oh_s[cand_s] = 1'b1;
            end else begin
                grant_found_s = grant_found_s;
            end
        end
        next_ptr_s = wrap_add(winner_s, ID_W'(1));
    end

    // Operand mux selecting the winner's packed a/b/c fields.
    always_comb begin
        win_a_s = '0;
        win_b_s = '0;
        win_c_s = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner_s == ID_W'(k)) begin
                win_a_s = req_a_i[k*DATA_W +: DATA_W];
                win_b_s = req_b_i[k*DATA_W +: DATA_W];
                win_c_s = req_c_i[k*DATA_W +: DATA_W];
            end else begin
                win_a_s = win_a_s;
            end
        end
    end

    // Grant is only offered in IDLE; held low during reset so every output reads 0.
    always_comb begin
        if ((state_r == ST_IDLE) && !rst_i) begin
            req_ready_s = grant_oh_s;
        end else begin
            req_ready_s = '0;
        end
    end

    // Control FSM, round-robin pointer, operand and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r     <= ST_IDLE;
            rr_ptr_r    <= '0;
            rsp_id_r    <= '0;
            mac_a_r     <= '0;
            mac_b_r     <= '0;
            mac_c_r     <= '0;
            rsp_d_r     <= '0;
            rsp_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_found_s) begin
                        mac_a_r  <= win_a_s;
                        mac_b_r  <= win_b_s;
                        mac_c_r  <= win_c_s;
                        rsp_id_r <= winner_s;
                        rr_ptr_r <= next_ptr_s;
                        state_r  <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Shared unit has had a full cycle to settle on mac_*_o.
                    rsp_d_r     <= mac_d_i;
                    rsp_valid_r <= 1'b1;
                    state_r     <= ST_RESP;
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_s;
    assign mac_a_o     = mac_a_r;
    assign mac_b_o     = mac_b_r;
    assign mac_c_o     = mac_c_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_id_o    = rsp_id_r;
    assign rsp_d_o     = rsp_d_r;
    assign busy_o      = (state_r != ST_IDLE);

endmodule

// File: tb/tb_mac_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mac_rr_arbiter
// Directed bench for mac_rr_arbiter with a behavioural multiply-add unit and a
// scoreboard queue. Expected results are pushed when a request is accepted
// and popped when a response handshake completes.
// -----------------------------------------------------------------------------
module tb_mac_rr_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 8;
    localparam int ID_W    = 2;

    typedef struct packed {
        logic [ID_W-1:0]     id;
        logic [2*DATA_W-1:0] d;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst_i;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_a;
    logic [NUM_REQ*DATA_W-1:0] req_b;
    logic [NUM_REQ*DATA_W-1:0] req_c;
    logic [DATA_W-1:0]         mac_a;
    logic [DATA_W-1:0]         mac_b;
    logic [DATA_W-1:0]         mac_c;
    logic [2*DATA_W-1:0]       mac_d;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [2*DATA_W-1:0]       rsp_d;
    logic                      busy;

    logic [DATA_W-1:0] op_a [NUM_REQ];
    logic [DATA_W-1:0] op_b [NUM_REQ];
    logic [DATA_W-1:0] op_c [NUM_REQ];

    exp_t              exp_q[$];
    int                grant_log[$];
    logic [15:0]       rsp_log[$];
    int                n_checks;
    int                n_fail;
    int                n_rsp;
    logic              auto_drop;

    int                exp_order[5] = '{0, 1, 2, 3, 0};
    logic [15:0]       exp_res[4]   = '{16'h0002, 16'h0005, 16'h0008, 16'h000B};

    always #5 clk = ~clk;

    // Pack per-port operands onto the flat buses.
    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_a[k*DATA_W +: DATA_W] = op_a[k];
            req_b[k*DATA_W +: DATA_W] = op_b[k];
            req_c[k*DATA_W +: DATA_W] = op_c[k];
        end
    end

    // Behavioural shared multiply-add unit.
    assign mac_d = {8'h00, mac_a} * {8'h00, mac_b} + {8'h00, mac_c};

    mac_rr_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_a_i     (req_a),
        .req_b_i     (req_b),
        .req_c_i     (req_c),
        .mac_a_o     (mac_a),
        .mac_b_o     (mac_b),
        .mac_c_o     (mac_c),
        .mac_d_i     (mac_d),
        .rsp_valid_o (rsp_valid),
        .rsp_ready_i (rsp_ready),
        .rsp_id_o    (rsp_id),
        .rsp_d_o     (rsp_d),
        .busy_o      (busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_req"}, {60'd0, req_ready}, 64'd0);
        chk({tag, "_mac"}, {40'd0, mac_a, mac_b, mac_c}, 64'd0);
        chk({tag, "_rsp"}, {44'd0, rsp_valid, rsp_id, rsp_d, busy}, 64'd0);
    endtask

    // One clock: observe handshakes just before the edge, then let requesters react.
    task automatic step();
        int   acc;
        exp_t e;
        acc = -1;
        #1;
        if (!rst_i) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    e.id = 2'(k);
                    e.d  = 16'(op_a[k]) * 16'(op_b[k]) + 16'(op_c[k]);
                    exp_q.push_back(e);
                    grant_log.push_back(k);
                    acc = k;
                end
            end
            if (rsp_valid && rsp_ready) begin
                chk("sb_depth", 64'(exp_q.size()), 64'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_id", 64'(rsp_id), 64'(e.id));
                    chk("sb_d", 64'(rsp_d), 64'(e.d));
                end
                rsp_log.push_back(rsp_d);
                n_rsp++;
            end
        end
        @(posedge clk);
        #1;
        if (acc >= 0 && auto_drop) req_valid[acc] = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_rsp(input string tag, input int budget);
        int start;
        start = n_rsp;
        for (int i = 0; i < budget && n_rsp == start; i++) step();
        chk({tag, "_rsp_seen"}, 64'(n_rsp != start), 64'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        n_rsp     = 0;
        auto_drop = 1'b1;
        rst_i     = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            op_a[k] = 8'h00;
            op_b[k] = 8'h00;
            op_c[k] = 8'h00;
        end
        @(negedge clk);

        // 1. Reset only.
        for (int i = 0; i < 5; i++) begin
            chk_all_zero("t1_reset");
            step();
        end
        rst_i = 1'b0;

        // 2. Single request on port 2.
        rsp_ready = 1'b1;
        op_a[2] = 8'h04; op_b[2] = 8'h05; op_c[2] = 8'h06;
        req_valid[2] = 1'b1;
        #1;
        chk("t2_ready", 64'(req_ready), 64'b0100);
        step();
        chk("t2_exec_busy", 64'(busy), 64'd1);
        chk("t2_exec_valid", 64'(rsp_valid), 64'd0);
        chk("t2_mac_ops", {40'd0, mac_a, mac_b, mac_c}, 64'h040506);
        chk("t2_exec_ready", 64'(req_ready), 64'd0);
        step();
        chk("t2_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("t2_rsp_id", 64'(rsp_id), 64'd2);
        chk("t2_rsp_d", 64'(rsp_d), 64'h001A);
        step();
        chk("t2_busy_drop", 64'(busy), 64'd0);
        chk("t2_valid_drop", 64'(rsp_valid), 64'd0);

        // Reset so the pointer starts at 0 for the fairness sequence.
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;

        // 3. All ports continuously valid.
        auto_drop = 1'b0;
        grant_log.delete();
        rsp_log.delete();
        for (int k = 0; k < NUM_REQ; k++) begin
            op_a[k] = 8'(k + 1); op_b[k] = 8'h02; op_c[k] = 8'(k);
        end
        req_valid = 4'hF;
        for (int i = 0; i < 40 && grant_log.size() < 5; i++) step();
        req_valid = '0;
        auto_drop = 1'b1;
        wait_rsp("t3_drain", 10);
        chk("t3_grant_count", 64'(grant_log.size()), 64'd5);
        for (int i = 0; i < 5 && i < grant_log.size(); i++)
            chk($sformatf("t3_grant_%0d", i), 64'(grant_log[i]), 64'(exp_order[i]));
        for (int i = 0; i < 4 && i < rsp_log.size(); i++)
            chk($sformatf("t3_result_%0d", i), 64'(rsp_log[i]), 64'(exp_res[i]));

        // 4. Backpressure with another port waiting.
        rsp_ready = 1'b0;
        op_a[1] = 8'h03; op_b[1] = 8'h07; op_c[1] = 8'h09;
        req_valid[1] = 1'b1;
        #1;
        chk("t4_first_ready", 64'(req_ready), 64'b0010);
        step();
        op_a[3] = 8'h10; op_b[3] = 8'h10; op_c[3] = 8'h01;
        req_valid[3] = 1'b1;
        step();
        for (int i = 0; i < 6; i++) begin
            chk("t4_hold_valid", 64'(rsp_valid), 64'd1);
            chk("t4_hold_id", 64'(rsp_id), 64'd1);
            chk("t4_hold_d", 64'(rsp_d), 64'h001E);
            chk("t4_hold_ready", 64'(req_ready), 64'd0);
            step();
        end
        rsp_ready = 1'b1;
        step();
        #1;
        chk("t4_next_grant", 64'(req_ready), 64'b1000);
        wait_rsp("t4_second", 10);
        chk("t4_second_d", 64'(rsp_log[$]), 64'h0101);

        // 5. Extreme operand values.
        op_a[2] = 8'hFF; op_b[2] = 8'hFF; op_c[2] = 8'hFF;
        req_valid[2] = 1'b1;
        wait_rsp("t5_max", 10);
        chk("t5_max_d", 64'(rsp_log[$]), 64'hFF00);
        op_a[1] = 8'h00; op_b[1] = 8'h00; op_c[1] = 8'h00;
        req_valid[1] = 1'b1;
        wait_rsp("t5_zero", 10);
        chk("t5_zero_d", 64'(rsp_log[$]), 64'h0000);

        // 6a. Reset while in EXEC: the transaction is dropped.
        op_a[3] = 8'h11; op_b[3] = 8'h02; op_c[3] = 8'h03;
        req_valid[3] = 1'b1;
        step();
        chk("t6_exec_busy", 64'(busy), 64'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        exp_q.delete();
        chk_all_zero("t6a_after_reset");
        for (int i = 0; i < 3; i++) begin
            chk("t6a_no_rsp", 64'(rsp_valid), 64'd0);
            step();
        end

        // 6b. Reset while in RESP.
        rsp_ready = 1'b0;
        req_valid[2] = 1'b1;
        step();
        step();
        chk("t6b_in_resp", 64'(rsp_valid), 64'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        exp_q.delete();
        chk_all_zero("t6b_after_reset");
        rsp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t6b_no_rsp", 64'(rsp_valid), 64'd0);
            step();
        end

        // Pointer back at 0: port 0 beats port 3.
        op_a[0] = 8'h02; op_b[0] = 8'h03; op_c[0] = 8'h04;
        req_valid[0] = 1'b1;
        req_valid[3] = 1'b1;
        #1;
        chk("t6_ptr_reset_grant", 64'(req_ready), 64'b0001);
        wait_rsp("t6_port0", 10);
        chk("t6_port0_d", 64'(rsp_log[$]), 64'h000A);
        wait_rsp("t6_port3", 10);
        chk("t6_port3_d", 64'(rsp_log[$]), 64'h0025);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
